// File: rtl/grupa_a.sv
// rtl/grupa_a.sv - saturating positive/negative event accumulators with a greater-than flag
module grupa_a #(
    parameter int CW = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iEN,
    input  logic [2:0]    iDEC,
    output logic [CW-1:0] oCNTP,
    output logic [CW-1:0] oCNTN,
    output logic          oGREAT
);

    localparam int SW = CW + 1;
    localparam logic [CW-1:0] maxCount = '1;

    logic          isPos;
    logic          isNeg;
    logic [2:0]    negMag;
    logic [SW-1:0] sumP;
    logic [SW-1:0] sumN;
    logic [CW-1:0] nextP;
    logic [CW-1:0] nextN;

    // Two's-complement negate of a 3-bit value; 3'b100 yields 3'b100, read unsigned as 4.
    always_comb begin
        isPos  = !iDEC[2] && (iDEC != 3'd0);
        isNeg  = iDEC[2];
        negMag = ~iDEC + 3'd1;
        sumP   = {1'b0, oCNTP} + SW'(iDEC);
        sumN   = {1'b0, oCNTN} + SW'(negMag);
        nextP  = sumP[CW] ? maxCount : sumP[CW-1:0];
        nextN  = sumN[CW] ? maxCount : sumN[CW-1:0];
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            oCNTP <= '0;
            oCNTN <= '0;
        end else if (iEN) begin
            if (isPos) begin
                oCNTP <= nextP;
            end
            if (isNeg) begin
                oCNTN <= nextN;
            end
        end
    end

    assign oGREAT = (oCNTP > oCNTN);

endmodule

// File: tb/tb_grupa_a.sv
// tb/tb_grupa_a.sv - directed and randomized check of grupa_a against an integer model
module tb_grupa_a;

    localparam int CW = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic          iCLK;
    logic          iRST;
    logic          iEN;
    logic [2:0]    iDEC;
    logic [CW-1:0] oCNTP;
    logic [CW-1:0] oCNTN;
    logic          oGREAT;

    int nVec;
    int nErr;
    int modelP;
    int modelN;

    grupa_a #(.CW(CW)) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (iEN),
        .iDEC  (iDEC),
        .oCNTP (oCNTP),
        .oCNTN (oCNTN),
        .oGREAT(oGREAT)
    );

    initial iCLK = 1'b0;
    always #10 iCLK = ~iCLK;

    task automatic chk(input string tag, input int obs, input int exp);
        nVec++;
        if (obs != exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the input is a signed number; add its size to whichever side its sign picks, clamp at MAXV.
    task automatic step(input logic rst, input logic en, input logic [2:0] dec, input string tag);
        int v;
        iRST = rst;
        iEN  = en;
        iDEC = dec;
        @(posedge iCLK);
        v = dec[2] ? int'(dec) - 8 : int'(dec);
        if (!rst) begin
            modelP = 0;
            modelN = 0;
        end else if (en) begin
            if (v > 0) modelP = (modelP + v > MAXV) ? MAXV : modelP + v;
            if (v < 0) modelN = (modelN - v > MAXV) ? MAXV : modelN - v;
        end
        #1;
        chk({tag, ".cntp"}, int'(oCNTP), modelP);
        chk({tag, ".cntn"}, int'(oCNTN), modelN);
        chk({tag, ".great"}, int'(oGREAT), int'(modelP > modelN));
    endtask

    initial begin
        nVec   = 0;
        nErr   = 0;
        modelP = 0;
        modelN = 0;
        iRST   = 1'b0;
        iEN    = 1'b0;
        iDEC   = 3'b000;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'b000, "reset");
        chk("reset.abs_p", int'(oCNTP), 0);
        chk("reset.abs_g", int'(oGREAT), 0);

        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 3'b010, "pos_sat");
        chk("pos_sat.abs", int'(oCNTP), 15);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 3'b000, "zero");

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b011, "mid_reset");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'b111, "neg_one");
        chk("neg_one.abs", int'(oCNTN), 5);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'b001, "sign_change");
        chk("equal.abs_g", int'(oGREAT), 0);
        step(1'b1, 1'b1, 3'b001, "one_more");
        chk("one_more.abs_g", int'(oGREAT), 1);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'b100, "hold");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b000, "clr");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b100, "neg_sat");
        chk("neg_sat.abs", int'(oCNTN), 15);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
